// File: rtl/vga_sync_tracker.sv
// Sink-side VGA timing recovery: rebuilds x/y position and lock state from h_sync/v_sync alone.
// Define VGA_SYNC_TRACKER_STATS_EN to add the measured line/frame length outputs.
module vga_sync_tracker #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned LOCK_LINES = 4,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_tick,
    input  logic       h_sync,
    input  logic       v_sync,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       de,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
`ifdef VGA_SYNC_TRACKER_STATS_EN
    ,
    output logic [9:0] meas_h_total,
    output logic [9:0] meas_v_total
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_SS     = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0]  V_SS     = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
    localparam logic [10:0] WD_LIMIT = 11'(2 * H_TOTAL);
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_LINES);
    localparam logic [3:0]  MISS_N   = 4'(MISS_LIMIT);

    typedef enum logic [1:0] {
        StSearch,
        StHTrack,
        StVTrack,
        StLocked
    } state_e;

    state_e      state_q, state_d;
    logic        h_prev_q, h_prev_d;
    logic        v_prev_q, v_prev_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  miss_q, miss_d;
    logic [3:0]  miss_inc;
    logic [10:0] wd_q, wd_d;

    logic        h_fall, v_fall;
    logic [9:0]  pred_x, pred_y;
    logic        h_match, v_match;
    logic        h_bad, v_bad;
    logic        fs_raw, err_raw;

    always_comb begin
        h_fall   = pix_tick & h_prev_q & ~h_sync;
        v_fall   = pix_tick & v_prev_q & ~v_sync;
        pred_x   = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;
        pred_y   = (pred_x != 10'd0) ? y_q : ((y_q == V_LAST) ? 10'd0 : y_q + 10'd1);
        h_match  = (pred_x == H_SS);
        v_match  = (pred_x == 10'd0) && (pred_y == V_SS);
        h_bad    = h_fall & ~h_match;
        v_bad    = v_fall & ~v_match;
        miss_inc = miss_q + 4'd1;
    end

    always_comb begin
        state_d  = state_q;
        h_prev_d = h_prev_q;
        v_prev_d = v_prev_q;
        x_d      = x_q;
        y_d      = y_q;
        good_d   = good_q;
        miss_d   = miss_q;
        wd_d     = wd_q;
        err_raw  = 1'b0;

        if (pix_tick) begin
            h_prev_d = h_sync;
            v_prev_d = v_sync;
            x_d      = h_fall ? H_SS : pred_x;
            y_d      = v_fall ? V_SS : pred_y;
            if (h_fall) begin
                wd_d = 11'd0;
            end else if (wd_q != 11'h7ff) begin
                wd_d = wd_q + 11'd1;
            end

            unique case (state_q)
                StSearch: begin
                    if (h_fall) begin
                        state_d = StHTrack;
                        good_d  = 4'd0;
                    end
                end
                StHTrack: begin
                    if (h_fall) begin
                        good_d = !h_match ? 4'd0 : ((good_q == 4'hf) ? good_q : good_q + 4'd1);
                    end
                    // Lock qualification uses this tick's line result as well.
                    if (v_fall && (good_d >= LOCK_N)) begin
                        state_d = StVTrack;
                    end
                end
                StVTrack: begin
                    if (h_bad) begin
                        state_d = StHTrack;
                        good_d  = 4'd0;
                    end else if (v_fall && v_match) begin
                        state_d = StLocked;
                        miss_d  = 4'd0;
                    end
                end
                StLocked: begin
                    if (h_bad || v_bad) begin
                        err_raw = 1'b1;
                        if (miss_inc >= MISS_N) begin
                            state_d = StSearch;
                            miss_d  = 4'd0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else if (h_fall) begin
                        miss_d = 4'd0;
                    end
                end
                default: state_d = StSearch;
            endcase

            // Lost line sync overrides whatever the FSM decided this tick.
            if (wd_d >= WD_LIMIT) begin
                state_d = StSearch;
            end
        end

        fs_raw = pix_tick & (state_d == StLocked) & (x_d == 10'd0) & (y_d == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StSearch;
            h_prev_q <= 1'b1;
            v_prev_q <= 1'b1;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            good_q   <= 4'd0;
            miss_q   <= 4'd0;
            wd_q     <= 11'd0;
        end else begin
            state_q  <= state_d;
            h_prev_q <= h_prev_d;
            v_prev_q <= v_prev_d;
            x_q      <= x_d;
            y_q      <= y_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        x_pos       = x_q;
        y_pos       = y_q;
        locked      = (state_q == StLocked);
        de          = locked && (x_q < H_VIS) && (y_q < V_VIS);
        frame_start = fs_raw & ~reset;
        sync_err    = err_raw & ~reset;
    end

`ifdef VGA_SYNC_TRACKER_STATS_EN
    logic [9:0] meas_h_q, meas_h_d;
    logic [9:0] meas_v_q, meas_v_d;
    logic [9:0] hcnt_q, hcnt_d;

    // The watchdog already counts ticks since the last h_fall, so it doubles as the line timer.
    always_comb begin
        meas_h_d = meas_h_q;
        meas_v_d = meas_v_q;
        hcnt_d   = hcnt_q;
        if (h_fall) begin
            meas_h_d = (wd_q >= 11'd1023) ? 10'd1023 : 10'(wd_q + 11'd1);
        end
        if (v_fall) begin
            meas_v_d = (hcnt_q == 10'd1023) ? hcnt_q : hcnt_q + {9'd0, h_fall};
            hcnt_d   = 10'd0;
        end else if (h_fall && (hcnt_q != 10'd1023)) begin
            hcnt_d = hcnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meas_h_q <= 10'd0;
            meas_v_q <= 10'd0;
            hcnt_q   <= 10'd0;
        end else begin
            meas_h_q <= meas_h_d;
            meas_v_q <= meas_v_d;
            hcnt_q   <= hcnt_d;
        end
    end

    assign meas_h_total = meas_h_q;
    assign meas_v_total = meas_v_q;
`endif

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Bench for vga_sync_tracker: a reduced-timing instance checked every cycle against a
// behavioural model, plus a full-size instance pinned with hand-computed positions.
module tb_vga_sync_tracker;

    localparam int HV = 16, HF = 4, HSW = 6, HB = 6;
    localparam int VV = 12, VF = 2, VSW = 2, VB = 4;
    localparam int HT = HV + HF + HSW + HB;   // 32
    localparam int VT = VV + VF + VSW + VB;   // 20
    localparam int HSS = HV + HF;             // 20
    localparam int VSS = VV + VF;             // 14
    localparam int FRAME = HT * VT;           // 640
    localparam int LOCK = 4, MISS = 3;

    logic       clk = 1'b0;
    logic       reset, pix_tick, h_sync, v_sync;
    logic [9:0] x_pos, y_pos;
    logic       de, locked, frame_start, sync_err;
    logic       d_tick, d_h, d_v;
    logic [9:0] d_x, d_y;
    logic       d_de, d_locked, d_fs, d_err;
`ifdef VGA_SYNC_TRACKER_STATS_EN
    logic [9:0] meas_h_total, meas_v_total, d_mh, d_mv;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_sync_tracker #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .LOCK_LINES(LOCK), .MISS_LIMIT(MISS)
    ) u_dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .h_sync(h_sync), .v_sync(v_sync),
        .x_pos(x_pos), .y_pos(y_pos), .de(de), .locked(locked),
        .frame_start(frame_start), .sync_err(sync_err)
`ifdef VGA_SYNC_TRACKER_STATS_EN
        , .meas_h_total(meas_h_total), .meas_v_total(meas_v_total)
`endif
    );

    vga_sync_tracker u_def (
        .clk(clk), .reset(reset), .pix_tick(d_tick), .h_sync(d_h), .v_sync(d_v),
        .x_pos(d_x), .y_pos(d_y), .de(d_de), .locked(d_locked),
        .frame_start(d_fs), .sync_err(d_err)
`ifdef VGA_SYNC_TRACKER_STATS_EN
        , .meas_h_total(d_mh), .meas_v_total(d_mv)
`endif
    );

    // Behavioural model state (reduced-timing instance).
    bit     m_valid = 1'b0;
    int     m_x, m_y, m_st, m_good, m_miss, m_hc, m_mh, m_mv;
    longint m_now, m_last;
    bit     m_hp, m_vp, e_fs, e_err;
    bit     obs_fs, obs_err, obs_de;

    // Generator / bookkeeping.
    int gx, gy, g_vfalls, err_cnt, unlock_cnt, windows, de_acc;
    bit g_vp, fs_seen;
    longint tick_idx, fs_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_st = 0; m_good = 0; m_miss = 0;
        m_hc = 0; m_mh = 0; m_mv = 0; m_now = 0; m_last = 0;
        m_hp = 1'b1; m_vp = 1'b1;
    endtask

    // States: 0 search, 1 line tracking, 2 frame tracking, 3 locked.
    task automatic model_tick(input bit hs, input bit vs);
        bit hf, vf, hm, vm;
        int px, py, nx, ny, st, wd;
        hf = m_hp && !hs;
        vf = m_vp && !vs;
        px = (m_x + 1) % HT;
        py = (px != 0) ? m_y : (m_y + 1) % VT;
        hm = (px == HSS);
        vm = (px == 0) && (py == VSS);
        nx = hf ? HSS : px;
        ny = vf ? VSS : py;
        m_now++;
        if (hf) begin
            m_mh = (m_now - m_last > 1023) ? 1023 : int'(m_now - m_last);
            m_last = m_now;
        end
        wd = (m_now - m_last > 2047) ? 2047 : int'(m_now - m_last);
        if (vf) begin
            m_mv = (m_hc + int'(hf) > 1023) ? 1023 : m_hc + int'(hf);
            m_hc = 0;
        end else if (hf && m_hc < 1023) begin
            m_hc++;
        end
        e_err = 1'b0;
        st = m_st;
        case (m_st)
            0: if (hf) begin st = 1; m_good = 0; end
            1: begin
                if (hf) m_good = hm ? ((m_good < 15) ? m_good + 1 : 15) : 0;
                if (vf && m_good >= LOCK) st = 2;
            end
            2: begin
                if (hf && !hm) begin st = 1; m_good = 0; end
                else if (vf && vm) begin st = 3; m_miss = 0; end
            end
            default: begin
                if ((hf && !hm) || (vf && !vm)) begin
                    e_err = 1'b1;
                    m_miss++;
                    if (m_miss >= MISS) begin st = 0; m_miss = 0; end
                end else if (hf) begin
                    m_miss = 0;
                end
            end
        endcase
        if (wd >= 2 * HT) st = 0;
        m_st = st; m_x = nx; m_y = ny; m_hp = hs; m_vp = vs;
        e_fs = (st == 3) && (nx == 0) && (ny == 0);
    endtask

    // One clock: drive, compare against the model just before the edge, advance the model.
    task automatic step(input bit rst, input bit tk, input bit hs, input bit vs);
        reset = rst; pix_tick = tk; h_sync = hs; v_sync = vs;
        #1;
        if (m_valid) begin
            chk("x_pos", x_pos, m_x);
            chk("y_pos", y_pos, m_y);
            chk("locked", locked, m_st == 3);
            chk("de", de, (m_st == 3) && (m_x < HV) && (m_y < VV));
`ifdef VGA_SYNC_TRACKER_STATS_EN
            chk("meas_h_total", meas_h_total, m_mh);
            chk("meas_v_total", meas_v_total, m_mv);
`endif
        end
        obs_de = de;
        if (rst) begin
            model_reset();
            e_fs = 1'b0; e_err = 1'b0;
        end else if (tk) begin
            model_tick(hs, vs);
        end else begin
            e_fs = 1'b0; e_err = 1'b0;
        end
        if (m_valid) begin
            chk("frame_start", frame_start, e_fs);
            chk("sync_err", sync_err, e_err);
        end
        obs_fs = frame_start;
        obs_err = sync_err;
        if (rst) m_valid = 1'b1;
        @(negedge clk);
    endtask

    // One generator pixel, preceded by 0..3 idle clocks with junk on the sync lines.
    task automatic gen_tick(input int shift, input bit mask_h, input bit track);
        int idle, sx, sy;
        bit hs, vs, was;
        idle = $urandom_range(0, 3);
        for (int i = 0; i < idle; i++)
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        hs = mask_h || !(gx >= HSS + shift && gx < HSS + shift + HSW);
        vs = !(gy >= VSS && gy < VSS + VSW);
        if (g_vp && !vs) g_vfalls++;
        g_vp = vs;
        was = locked;
        sx = gx; sy = gy;
        step(1'b0, 1'b1, hs, vs);
        tick_idx++;
        if (obs_err) err_cnt++;
        if (!locked) unlock_cnt++;
        if (track && locked && was) begin
            chk("x_track", x_pos, sx);
            chk("y_track", y_pos, sy);
            if (obs_fs) begin
                if (fs_seen) begin
                    chk("frame_period", 32'(tick_idx - fs_last), FRAME);
                    chk("de_per_frame", de_acc, HV * VV);
                    windows++;
                end
                fs_seen = 1'b1;
                fs_last = tick_idx;
                de_acc = 0;
            end
            de_acc += int'(obs_de);
        end
        gx = (gx + 1) % HT;
        if (gx == 0) gy = (gy + 1) % VT;
    endtask

    task automatic gen_restart();
        gx = 0; gy = 0; g_vp = 1'b1; g_vfalls = 0;
    endtask

    initial begin
        int lock_vf;
        reset = 1'b1; pix_tick = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
        d_tick = 1'b0; d_h = 1'b1; d_v = 1'b1;
        tick_idx = 0; fs_last = 0; fs_seen = 1'b0; windows = 0; de_acc = 0;
        err_cnt = 0; unlock_cnt = 0;
        @(negedge clk);
        reset = 1'b0;

        // Full-size instance: literal positions for the 640x480 constants.
        chk("def_reset_x", d_x, 0);
        chk("def_reset_locked", d_locked, 0);
        d_tick = 1'b1;
        repeat (10) @(negedge clk);
        chk("def_freerun_x", d_x, 10);
        d_h = 1'b0;
        @(negedge clk);
        chk("def_hfall_x", d_x, 656);
        d_h = 1'b1;
        repeat (143) @(negedge clk);
        chk("def_last_x", d_x, 799);
        chk("def_last_y", d_y, 0);
        @(negedge clk);
        chk("def_wrap_x", d_x, 0);
        chk("def_wrap_y", d_y, 1);
        d_v = 1'b0;
        @(negedge clk);
        chk("def_vfall_y", d_y, 490);
        chk("def_vfall_x", d_x, 1);
        @(negedge clk);
        chk("def_vlow_y", d_y, 490);
        chk("def_unlocked_de", d_de, 0);
        chk("def_no_err", d_err, 0);
        d_tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("def_hold_x", d_x, 2);

        // Reduced instance: reset, idle ticks.
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("idle_locked", locked, 0);
        chk("idle_de", de, 0);
        chk("idle_fs", obs_fs, 0);
        chk("idle_err", obs_err, 0);

        // Random sync noise exercises odd edge combinations against the model.
        repeat (600)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) != 0),
                 1'($urandom_range(0, 9) != 0));

        // Nominal stream from reset: lock lands on the second v_sync fall.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        gen_restart();
        lock_vf = -1;
        for (int i = 0; i < 4 * FRAME && lock_vf < 0; i++) begin
            gen_tick(0, 1'b0, 1'b0);
            if (locked) lock_vf = g_vfalls;
        end
        chk("lock_at_vfall", lock_vf, 2);

        repeat (3 * FRAME) gen_tick(0, 1'b0, 1'b1);
        chk("frame_windows", windows, 2);
`ifdef VGA_SYNC_TRACKER_STATS_EN
        chk("stats_h_total", meas_h_total, HT);
        chk("stats_v_total", meas_v_total, VT);
`endif

        // One line's pulse 3 pixels late: the reload leaves x 3 behind, so the next true
        // edge mismatches too; two misses stay under the limit.
        while (!(gx == 0 && gy == 3)) gen_tick(0, 1'b0, 1'b1);
        err_cnt = 0; unlock_cnt = 0;
        repeat (HT) gen_tick(3, 1'b0, 1'b0);
        repeat (2 * HT) gen_tick(0, 1'b0, 1'b0);
        chk("shift_err_pulses", err_cnt, 2);
        chk("shift_stays_locked", unlock_cnt, 0);
        fs_seen = 1'b0;
        repeat (HT) gen_tick(0, 1'b0, 1'b1);

        // Lose h_sync for two line periods: watchdog drops lock, then re-lock.
        while (!(gx == 0 && gy == 6)) gen_tick(0, 1'b0, 1'b1);
        repeat (2 * HT) gen_tick(0, 1'b1, 1'b0);
        chk("wd_unlocked", locked, 0);
        chk("wd_de", de, 0);
        lock_vf = -1;
        for (int i = 0; i < 4 * FRAME && lock_vf < 0; i++) begin
            gen_tick(0, 1'b0, 1'b0);
            if (locked) lock_vf = 1;
        end
        chk("relock", lock_vf, 1);
        fs_seen = 1'b0;
        repeat (FRAME + HT) gen_tick(0, 1'b0, 1'b1);

        // Reset while locked with no pixel tick.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_locked", locked, 0);
        chk("rst_x", x_pos, 0);
        chk("rst_y", y_pos, 0);
        chk("rst_de", de, 0);
        repeat (4) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
